// File: rtl/almacen_plant_if.sv
// Actuator/sensor bundle between a warehouse axis controller and its plant model.
// The controller drives the actuators (A, C); the plant drives the sensors.
interface almacen_plant_if #(
  parameter int W = 4
);
  logic         A;
  logic         C;
  logic         S1;
  logic         S2;
  logic         moving;
  logic         fault;
  logic [W-1:0] pos;

  modport master (
    output A, C,
    input  S1, S2, moving, fault, pos
  );

  modport slave (
    input  A, C,
    output S1, S2, moving, fault, pos
  );
endinterface

// File: rtl/almacen_plant.sv
// Behavioural plant of one shuttle/gate axis: turns advance/return commands
// into a travelling position with home/end limit switches, a move indicator
// and a latched fault when both actuators are driven at once.
module almacen_plant #(
  parameter int TRAVEL = 8,
  parameter int DIV    = 2,
  parameter int W      = 4
) (
  input  logic          clk,
  input  logic          rstn,
  almacen_plant_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  TRAVEL_W = W'(TRAVEL);
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    REV   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [PW-1:0]  presc;
  logic [PW-1:0]  presc_next;
  logic [W-1:0]   pos_q;
  logic [W-1:0]   pos_next;
  logic [PW-1:0]  presc_eff;
  logic           can_move;

  // Next-state decode, prescaler and saturating position update.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    state_next = IDLE;
    presc_next = '0;
    pos_next   = pos_q;
    presc_eff  = '0;
    can_move   = 1'b0;

    if (state == FAULT) begin
      state_next = (bus.A || bus.C) ? FAULT : IDLE;
    end else begin
      unique case ({bus.A, bus.C})
        2'b10:   state_next = FWD;
        2'b01:   state_next = REV;
        2'b11:   state_next = FAULT;
        default: state_next = IDLE;
      endcase
    end

    can_move = ((state_next == FWD) && (pos_q < TRAVEL_W)) ||
               ((state_next == REV) && (pos_q != '0));

    // A direction change restarts the count: this edge is the first of the
    // new run, so the partial count from the old direction is dropped.
    presc_eff = (state_next == state) ? presc : '0;

    if (can_move) begin
      if (presc_eff == DIV_LAST) begin
        presc_next = '0;
        pos_next   = (state_next == FWD) ? pos_q + 1'b1 : pos_q - 1'b1;
      end else begin
        presc_next = presc_eff + 1'b1;
      end
    end
  end

  // State, position and registered sensor outputs, all updated together.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rstn) begin
      state      <= IDLE;
      presc      <= '0;
      pos_q      <= '0;
      bus.S1     <= 1'b1;
      bus.S2     <= 1'b0;
      bus.moving <= 1'b0;
      bus.fault  <= 1'b0;
    end else begin
      state      <= state_next;
      presc      <= presc_next;
      pos_q      <= pos_next;
      bus.S1     <= (pos_next == '0);
      bus.S2     <= (pos_next == TRAVEL_W);
      bus.moving <= ((state_next == FWD) && (pos_next < TRAVEL_W)) ||
                    ((state_next == REV) && (pos_next != '0));
      bus.fault  <= (state_next == FAULT);
    end
  end

  assign bus.pos = pos_q;

endmodule

// File: tb/tb_almacen_plant.sv
// Directed bench for almacen_plant with TRAVEL=8, DIV=2, W=4.
module tb_almacen_plant;

  logic clk;
  logic rstn;
  int   vectors;
  int   miscompares;

  almacen_plant_if #(.W(4)) bus ();

  almacen_plant #(.TRAVEL(8), .DIV(2), .W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int p, input logic s1, input logic s2,
                           input logic mv, input logic flt);
    check({tag, ".pos"},    32'(bus.pos),    32'(p));
    check({tag, ".S1"},     32'(bus.S1),     32'(s1));
    check({tag, ".S2"},     32'(bus.S2),     32'(s2));
    check({tag, ".moving"}, 32'(bus.moving), 32'(mv));
    check({tag, ".fault"},  32'(bus.fault),  32'(flt));
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic c);
    bus.A = a;
    bus.C = c;
  endtask

  initial begin
    int p;
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    drive(1'b1, 1'b0);
    #2;

    // 1. Reset overrides A=1 for two edges, then release with A=0.
    for (int e = 1; e <= 2; e++) begin
      edges(1);
      check_all($sformatf("rst.e%0d", e), 0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    rstn = 1'b1;
    drive(1'b0, 1'b0);
    edges(1);
    check_all("rst.release", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 2. Forward full travel with saturation at 8.
    drive(1'b1, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      edges(1);
      p = (e / 2 > 8) ? 8 : e / 2;
      check_all($sformatf("fwd.e%0d", e), p, p == 0, p == 8, p < 8, 1'b0);
    end

    // 3. Return to home.
    drive(1'b0, 1'b1);
    for (int e = 1; e <= 16; e++) begin
      edges(1);
      p = 8 - e / 2;
      check_all($sformatf("rev.e%0d", e), p, p == 0, p == 8, p > 0, 1'b0);
    end

    // 4. Partial and reversing commands.
    drive(1'b1, 1'b0);
    edges(1);
    check_all("part.a1", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0);
    edges(1);
    check_all("part.idle", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    edges(3);
    check_all("part.a3", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1);
    edges(1);
    check_all("part.c1", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    edges(1);
    check_all("part.c2", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 5. Fault entry, hold and exit.
    drive(1'b1, 1'b0);
    edges(6);
    check_all("flt.pos3", 3, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1);
    edges(1);
    check_all("flt.enter", 3, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      edges(1);
      check_all($sformatf("flt.hold%0d", e), 3, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0);
    edges(1);
    check_all("flt.exit", 3, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    edges(1);
    check_all("flt.a1", 3, 1'b0, 1'b0, 1'b1, 1'b0);
    edges(1);
    check_all("flt.a2", 4, 1'b0, 1'b0, 1'b1, 1'b0);

    // 6. Reset mid-travel and while faulted.
    edges(2);
    check_all("mid.pos5", 5, 1'b0, 1'b0, 1'b1, 1'b0);
    rstn = 1'b0;
    edges(1);
    check_all("mid.rst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    drive(1'b1, 1'b1);
    edges(1);
    check_all("mid.fault", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    rstn = 1'b0;
    edges(1);
    check_all("mid.fault_rst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    drive(1'b0, 1'b0);
    edges(1);
    check_all("mid.after", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
